// File: rtl/seg_scan_n_if.sv
// Bus between the CPU write path / board pins and the multiplexed display scanner.
// Valid/ready is not used: load is a single-cycle write strobe, the other inputs are level signals.
interface seg_scan_n_if #(
    parameter int DIGITS = 8
) ();
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp;
    logic                  blank_lz;
    logic [DIGITS-1:0]     blink_mask;
    logic [DIGITS-1:0]     ena;
    logic [7:0]            light;
    logic                  frame;

    modport master (
        output load, data, dp, blank_lz, blink_mask,
        input  ena, light, frame
    );

    modport slave (
        input  load, data, dp, blank_lz, blink_mask,
        output ena, light, frame
    );
endinterface

// File: rtl/seg_scan_n.sv
// N-digit multiplexed 7-segment scanner with prescaler, decimal points,
// leading-zero blanking, per-digit blink and a frame strobe.
module seg_scan_n #(
    parameter int DIGITS       = 8,
    parameter int DIV          = 2000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_n_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [BW-1:0]       bcnt;
    logic                phase;
    logic                tick;
    logic                wrap;
    logic [DIGITS-1:0]   zero_run;
    logic [3:0]          nib;
    logic                blanked;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hFC;
            4'h1: s = 8'h60;
            4'h2: s = 8'hDA;
            4'h3: s = 8'hF2;
            4'h4: s = 8'h66;
            4'h5: s = 8'hB6;
            4'h6: s = 8'hBE;
            4'h7: s = 8'hE0;
            4'h8: s = 8'hFE;
            4'h9: s = 8'hE6;
            4'hA: s = 8'hEE;
            4'hB: s = 8'h3E;
            4'hC: s = 8'h9C;
            4'hD: s = 8'h7A;
            4'hE: s = 8'h9E;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // zero_run[i]: digits i..DIGITS-1 all hold nibble 0 with dp clear.
    always_comb begin : lz_scan
        logic run;
        run      = 1'b1;
        zero_run = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run         = run && (sh_data[4*i +: 4] == 4'h0) && !sh_dp[i];
            zero_run[i] = run;
        end
    end

    always_comb begin
        nib     = sh_data[{idx, 2'b00} +: 4];
        blanked = (bus.blink_mask[idx] && phase) ||
                  (bus.blank_lz && (idx != '0) && zero_run[idx]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_data <= '0;
            sh_dp   <= '0;
        end else if (bus.load) begin
            sh_data <= bus.data;
            sh_dp   <= bus.dp;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            idx   <= '0;
            bcnt  <= '0;
            phase <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            // Blink phase flips once every BLINK_FRAMES completed frames.
            if (wrap) begin
                if (bcnt == BLINK_LAST) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ena   <= '0;
            bus.light <= '0;
            bus.frame <= 1'b0;
        end else begin
            bus.ena   <= blanked ? '0 : (DIGITS'(1) << idx);
            bus.light <= blanked ? 8'h00 : (seg7(nib) | {7'b0, sh_dp[idx]});
            bus.frame <= wrap;
        end
    end
endmodule

// File: tb/tb_seg_scan_n.sv
// Self-checking bench for seg_scan_n (DIGITS=4, DIV=3, BLINK_FRAMES=2) against
// a timeline model derived from the edge count since reset release.
module tb_seg_scan_n;
    localparam int DIG   = 4;
    localparam int DIV_T = 3;
    localparam int BF    = 2;
    localparam int FRAME_LEN = DIV_T * DIG;
    localparam logic [7:0] SEG [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                        8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    logic clk;
    logic rst;
    seg_scan_n_if #(.DIGITS(DIG)) bus ();

    seg_scan_n #(.DIGITS(DIG), .DIV(DIV_T), .BLINK_FRAMES(BF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    logic [4*DIG-1:0] m_data = '0;
    logic [DIG-1:0]   m_dp   = '0;
    logic [DIG-1:0]   exp_ena;
    logic [7:0]       exp_light;
    logic             exp_frame;

    // Expected outputs after edge k follow from k alone: which digit slot,
    // how many frames have completed, and the shadow contents before the edge.
    task automatic cycle();
        int k, i, f, ph;
        logic lz, blank, ld;
        logic [4*DIG-1:0] ld_d;
        logic [DIG-1:0] ld_p;
        logic [3:0] v;
        k  = edge_n + 1;
        i  = ((k - 1) / DIV_T) % DIG;
        f  = (k - 1) / FRAME_LEN;
        ph = (f / BF) % 2;
        lz = bus.blank_lz && (i != 0);
        for (int j = i; j < DIG; j++)
            if (m_data[4*j +: 4] != 4'h0 || m_dp[j]) lz = 1'b0;
        blank = (bus.blink_mask[i] && ph == 1) || lz;
        v = m_data[4*i +: 4];
        exp_ena   = blank ? '0 : DIG'(1 << i);
        exp_light = blank ? 8'h00 : (SEG[v] | {7'b0, m_dp[i]});
        exp_frame = ((k % FRAME_LEN) == 0);
        ld   = bus.load;
        ld_d = bus.data;
        ld_p = bus.dp;
        @(posedge clk);
        #1;
        edge_n = k;
        if (ld) begin
            m_data = ld_d;
            m_dp   = ld_p;
        end
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b0;
        edge_n = 0;
        m_data = '0;
        m_dp   = '0;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.load = 1'b0; bus.data = '0; bus.dp = '0;
        bus.blank_lz = 1'b0; bus.blink_mask = '0;
        do_reset(5);
        n_checks++;
        if (bus.ena !== '0 || bus.light !== 8'h00 || bus.frame !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ena=%b light=%h frame=%b, expected 0/00/0",
                     bus.ena, bus.light, bus.frame);
        end
        rst = 1'b1;
    endtask

    task automatic run_checked(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            cycle();
            bus.load = 1'b0;
            n_checks++;
            if (bus.ena !== exp_ena) begin
                n_fail++;
                $display("FAIL %s_ena edge %0d: got %b expected %b", name, edge_n, bus.ena, exp_ena);
            end
            n_checks++;
            if (bus.light !== exp_light) begin
                n_fail++;
                $display("FAIL %s_light edge %0d: got %h expected %h", name, edge_n, bus.light, exp_light);
            end
            n_checks++;
            if (bus.frame !== exp_frame) begin
                n_fail++;
                $display("FAIL %s_frame edge %0d: got %b expected %b", name, edge_n, bus.frame, exp_frame);
            end
        end
    endtask

    task automatic test_scan();
        bus.data = 16'h1234;
        bus.load = 1'b1;
        run_checked("scan", 2 * FRAME_LEN);
    endtask

    task automatic test_leading_zero();
        bus.blank_lz = 1'b1;
        bus.dp = '0;
        bus.data = 16'h0050;
        bus.load = 1'b1;
        run_checked("lz", FRAME_LEN + 2);
        bus.dp = 4'b0100;
        bus.load = 1'b1;
        run_checked("lz_dp", FRAME_LEN + 2);
        n_checks++;
        if (SEG[0] + 8'h01 !== 8'hFD) begin
            n_fail++;
            $display("FAIL lz_dp_code: got %h expected FD", SEG[0] + 8'h01);
        end
    endtask

    task automatic test_all_zero();
        bus.blank_lz = 1'b1;
        bus.dp = '0;
        bus.data = '0;
        bus.load = 1'b1;
        run_checked("zero", FRAME_LEN + 2);
    endtask

    task automatic test_blink();
        bus.blank_lz = 1'b0;
        bus.blink_mask = 4'b0001;
        bus.data = 16'hABCD;
        bus.load = 1'b1;
        run_checked("blink", 5 * FRAME_LEN);
        bus.blink_mask = '0;
    endtask

    task automatic test_mid_reset();
        int guard;
        guard = 0;
        while (((edge_n / DIV_T) % DIG) != 2 && guard < 100) begin
            run_checked("pre_rst", 1);
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL mid_reset_reach: could not reach digit 2, got guard %0d expected < 100", guard);
        end
        run_checked("pre_rst", 1);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.ena !== '0 || bus.light !== 8'h00 || bus.frame !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: ena=%b light=%h frame=%b, expected 0/00/0",
                     bus.ena, bus.light, bus.frame);
        end
        do_reset(2);
        rst = 1'b1;
        run_checked("post_rst", FRAME_LEN + 3);
    endtask

    task automatic test_load_in_reset();
        bus.data = 16'hFFFF;
        bus.load = 1'b1;
        do_reset(3);
        n_checks++;
        if (bus.ena !== '0 || bus.light !== 8'h00) begin
            n_fail++;
            $display("FAIL load_in_reset: ena=%b light=%h, expected 0/00", bus.ena, bus.light);
        end
        bus.load = 1'b0;
        rst = 1'b1;
        run_checked("after_rst_load", FRAME_LEN);
        bus.load = 1'b1;
        run_checked("load_ffff", FRAME_LEN + 3);
    endtask

    task automatic test_random();
        for (int r = 0; r < 400; r++) begin
            bus.load       = ($urandom_range(0, 7) == 0);
            bus.data       = 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom);
            bus.dp         = 4'($urandom_range(0, 2) == 0 ? $urandom : 0);
            bus.blank_lz   = ($urandom_range(0, 31) == 0) ? ~bus.blank_lz : bus.blank_lz;
            bus.blink_mask = ($urandom_range(0, 31) == 0) ? 4'($urandom) : bus.blink_mask;
            cycle();
            n_checks++;
            if (bus.ena !== exp_ena || bus.light !== exp_light || bus.frame !== exp_frame) begin
                n_fail++;
                $display("FAIL random edge %0d: got %b/%h/%b expected %b/%h/%b", edge_n,
                         bus.ena, bus.light, bus.frame, exp_ena, exp_light, exp_frame);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_scan();
        test_leading_zero();
        test_all_zero();
        test_blink();
        test_mid_reset();
        test_load_in_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
